// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the button_debounce_n channel filters.
// Optional auto-repeat is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } ch_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int f_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: tick-qualified stability filter with registered level/press/rel.
// Auto-repeat press train is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
//
//   state      | meaning
//   ST_LOW     | accepted level 0, input agrees
//   ST_WAIT_HI | accepted level 0, input high, counting stable ticks
//   ST_HIGH    | accepted level 1, input agrees (repeat counter runs)
//   ST_WAIT_LO | accepted level 1, input low, counting stable ticks
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS  = 10
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = 500
  , parameter int REPEAT_PERIOD = 100
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_s,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_rel
);

  localparam int CW = f_cnt_width(STABLE_TICKS);

  ch_state_e     r_state;
  ch_state_e     w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_level;
  logic          r_press;
  logic          r_rel;
  logic          w_in_high;
  logic          w_press_d;
  logic          w_rel_d;
  logic          w_rep_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_level <= w_in_high;
      r_press <= w_press_d;
      r_rel   <= w_rel_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_LOW: begin
        if (i_s) begin
          w_state_d = ST_WAIT_HI;
          w_cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!i_s) begin
          w_state_d = ST_LOW;
        end else if (i_tick) begin
          if (r_cnt == CW'(STABLE_TICKS - 1)) w_state_d = ST_HIGH;
          else                                w_cnt_d   = r_cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!i_s) begin
          w_state_d = ST_WAIT_LO;
          w_cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (i_s) begin
          w_state_d = ST_HIGH;
        end else if (i_tick) begin
          if (r_cnt == CW'(STABLE_TICKS - 1)) w_state_d = ST_LOW;
          else                                w_cnt_d   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = ST_LOW;
        w_cnt_d   = '0;
      end
    endcase

    // Output edges come from the registered accepted level, so a bounce back
    // from a WAIT state can never produce a pulse.
    w_in_high = (r_state == ST_HIGH) || (r_state == ST_WAIT_LO);
    w_press_d = (w_in_high & ~r_level) | w_rep_pulse;
    w_rel_d   = r_level & ~w_in_high;
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = f_cnt_width(f_max(REPEAT_DELAY, REPEAT_PERIOD));

  logic [RW-1:0] r_rc;
  logic [RW-1:0] w_rc_d;
  logic          r_rep_phase;
  logic          w_rep_phase_d;
  logic          r_rep_hit;
  logic          w_rep_hit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc        <= '0;
      r_rep_phase <= 1'b0;
      r_rep_hit   <= 1'b0;
    end else begin
      r_rc        <= w_rc_d;
      r_rep_phase <= w_rep_phase_d;
      r_rep_hit   <= w_rep_hit_d;
    end
  end

  // Phase 0 waits out the initial delay, phase 1 repeats at the period;
  // WAIT_LO leaves the counter frozen so a short release glitch resumes it.
  always_comb begin
    w_rc_d        = r_rc;
    w_rep_phase_d = r_rep_phase;
    w_rep_hit_d   = 1'b0;
    if ((r_state == ST_LOW) || (r_state == ST_WAIT_HI)) begin
      w_rc_d        = '0;
      w_rep_phase_d = 1'b0;
    end else if ((r_state == ST_HIGH) && i_tick) begin
      if (r_rc == (r_rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
        w_rep_hit_d   = 1'b1;
        w_rc_d        = '0;
        w_rep_phase_d = 1'b1;
      end else begin
        w_rc_d = r_rc + 1'b1;
      end
    end
  end

  assign w_rep_pulse = r_rep_hit;
`else
  assign w_rep_pulse = 1'b0;
`endif

  assign o_level = r_level;
  assign o_press = r_press;
  assign o_rel   = r_rel;

endmodule

// File: rtl/button_debounce_n.sv
// N-channel push-button debouncer: 2-FF synchronisers, shared tick divider, per-channel filters.
// Define DEBOUNCE_AUTOREPEAT_EN to turn a held button into a periodic press train.
module button_debounce_n
  import debounce_pkg::*;
#(
  parameter int N             = 5,
  parameter int TICK_DIV      = 100000,
  parameter int STABLE_TICKS  = 10,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel
);

  localparam int TW = f_cnt_width(TICK_DIV - 1);

  if ((N < 1) || (TICK_DIV < 1) || (STABLE_TICKS < 1) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_param_check
    $error("button_debounce_n: all parameters must be >= 1");
  end

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // With TICK_DIV == 1 the counter sits at 0 and w_tick is constantly high.
  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS  (STABLE_TICKS)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      , .REPEAT_DELAY  (REPEAT_DELAY)
      , .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_s     (r_sync2[gi]),
      .i_tick  (w_tick),
      .o_level (level[gi]),
      .o_press (press[gi]),
      .o_rel   (rel[gi])
    );
  end

endmodule

// File: tb/tb_button_debounce_n.sv
// Self-checking bench for button_debounce_n: directed scenarios plus randomized inputs
// against a tick-arithmetic reference model; honours DEBOUNCE_AUTOREPEAT_EN.
module tb_button_debounce_n;

  localparam int ST = 4;
  localparam int RD = 8;
  localparam int RP = 3;
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_a  = '0;
  logic [1:0] in_b  = '0;
  logic [1:0] lvl_a, prs_a, rel_a;
  logic [1:0] lvl_b, prs_b, rel_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  button_debounce_n #(.N(2), .TICK_DIV(1), .STABLE_TICKS(ST),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .level(lvl_a), .press(prs_a), .rel(rel_a));

  button_debounce_n #(.N(2), .TICK_DIV(5), .STABLE_TICKS(ST),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .level(lvl_b), .press(prs_b), .rel(rel_b));

  // ---------------- reference model ----------------
  // Per edge j (1-based since reset release): ticks fall on j % div == 0. A new
  // value is accepted once it has been seen continuously and ST ticks have
  // elapsed strictly after the first edge it was seen. Held-high time counts
  // ticks spent accepted-high with agreeing input; repeats at RD, RD+RP, ...
  typedef struct packed {
    logic l;
    logic p;
    logic np;
    logic nr;
    int   h;
    int   d;
  } mstep_t;

  function automatic mstep_t m_step(input logic s, input logic l, input logic p,
                                    input int h, input int d, input int j, input int dd);
    mstep_t r;
    logic   tk;
    tk   = ((j % dd) == 0);
    r.l  = l;
    r.p  = p;
    r.np = 1'b0;
    r.nr = 1'b0;
    r.h  = h;
    r.d  = d;
    if (REP_ON && l && !p && tk) begin
      r.h = h + 1;
      if ((r.h >= RD) && (((r.h - RD) % RP) == 0)) r.np = 1'b1;
    end
    if (s != l) begin
      if (!p) begin
        r.p = 1'b1;
        r.d = j;
      end else if ((j / dd) - (d / dd) >= ST) begin
        r.l  = !l;
        r.p  = 1'b0;
        r.h  = 0;
        r.np = !l;
        r.nr = l;
      end
    end else begin
      r.p = 1'b0;
    end
    return r;
  endfunction

  int         m_j;
  logic       m_q1   [2][2];
  logic       m_q2   [2][2];
  logic       m_lvl  [2][2];
  logic       m_pend [2][2];
  int         m_h    [2][2];
  int         m_d    [2][2];
  logic [1:0] nxt_press [2];
  logic [1:0] nxt_rel   [2];
  logic [1:0] exp_level [2];
  logic [1:0] exp_press [2];
  logic [1:0] exp_rel   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_j <= 0;
      for (int u = 0; u < 2; u++) begin
        nxt_press[u] <= '0;
        nxt_rel[u]   <= '0;
        exp_level[u] <= '0;
        exp_press[u] <= '0;
        exp_rel[u]   <= '0;
        for (int c = 0; c < 2; c++) begin
          m_q1[u][c]   <= 1'b0;
          m_q2[u][c]   <= 1'b0;
          m_lvl[u][c]  <= 1'b0;
          m_pend[u][c] <= 1'b0;
          m_h[u][c]    <= 0;
          m_d[u][c]    <= 0;
        end
      end
    end else begin
      m_j <= m_j + 1;
      for (int u = 0; u < 2; u++) begin
        for (int c = 0; c < 2; c++) begin
          exp_level[u][c] <= m_lvl[u][c];
          exp_press[u][c] <= nxt_press[u][c];
          exp_rel[u][c]   <= nxt_rel[u][c];
          {m_lvl[u][c], m_pend[u][c], nxt_press[u][c], nxt_rel[u][c], m_h[u][c], m_d[u][c]}
            <= m_step(m_q2[u][c], m_lvl[u][c], m_pend[u][c], m_h[u][c], m_d[u][c],
                      m_j + 1, (u == 0) ? 1 : 5);
          m_q2[u][c] <= m_q1[u][c];
          m_q1[u][c] <= (u == 0) ? in_a[c] : in_b[c];
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b} !== 12'h000)
      $display("FAIL reset_state: got %b required 000000000000",
               {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b});
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b} !== 12'h000)
      $display("FAIL reset_idle: got %b required 000000000000",
               {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b});
    else n_pass++;
  endtask

  task automatic test_clean_step();
    logic [5:0] want;
    do_reset();
    in_a = 2'b01;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      want = {(k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00, 2'b00};
      n_total++;
      if ({lvl_a, prs_a, rel_a} !== want)
        $display("FAIL clean_step edge %0d: got lvl/prs/rel %b required %b", k,
                 {lvl_a, prs_a, rel_a}, want);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [2:0] want;
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      in_a[0] = (k < 20) ? (((k / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
      want = {k >= 27, k == 27, 1'b0};
      n_total++;
      if ({lvl_a[0], prs_a[0], rel_a[0]} !== want)
        $display("FAIL bounce edge %0d: got lvl/prs/rel %b required %b", k,
                 {lvl_a[0], prs_a[0], rel_a[0]}, want);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [1:0] want;
    do_reset();
    in_a = 2'b01;
    repeat (12) @(negedge clk);
    in_a = 2'b00;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      want = {k < 7, k == 7};
      n_total++;
      if ({lvl_a[0], rel_a[0]} !== want)
        $display("FAIL release edge %0d: got lvl/rel %b required %b", k,
                 {lvl_a[0], rel_a[0]}, want);
      else n_pass++;
    end
    in_a = 2'b01;
    repeat (12) @(negedge clk);
    for (int k = 0; k <= 17; k++) begin
      in_a[0] = (k >= 3);
      @(negedge clk);
      n_total++;
      if ({lvl_a[0], rel_a[0]} !== 2'b10)
        $display("FAIL release_glitch edge %0d: got lvl/rel %b required 10", k,
                 {lvl_a[0], rel_a[0]});
      else n_pass++;
    end
  endtask

  task automatic test_autorepeat();
    logic want;
    do_reset();
    in_a = 2'b01;
    for (int k = 0; k <= 37; k++) begin
      @(negedge clk);
      want = (k == 7) || (REP_ON && (k >= 15) && (((k - 15) % RP) == 0));
      n_total++;
      if (prs_a[0] !== want)
        $display("FAIL autorepeat edge %0d: got press %b required %b", k, prs_a[0], want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_a = 2'b10;
    repeat (10) @(negedge clk);
    in_a = 2'b11;
    repeat (4) @(negedge clk);
    n_total++;
    if (lvl_a !== 2'b10) $display("FAIL reset_mid_pre: got level %b required 10", lvl_a);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({lvl_a, prs_a, rel_a} !== 6'b0)
      $display("FAIL reset_mid_async: got lvl/prs/rel %b required 000000", {lvl_a, prs_a, rel_a});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      n_total++;
      if ({lvl_a, prs_a} !== {(k >= 7) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00})
        $display("FAIL reset_mid_rearm edge %0d: got lvl/prs %b required %b", k,
                 {lvl_a, prs_a}, {(k >= 7) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00});
      else n_pass++;
    end
  endtask

  task automatic test_tick_div();
    int r, e0, t1, lat;
    for (int trial = 0; trial < 3; trial++) begin
      do_reset();
      r = $urandom_range(0, 9);
      repeat (r) @(negedge clk);
      e0  = 3 + r;
      t1  = (((e0 + 2) / 5) + 1) * 5;
      lat = t1 + (ST - 1) * 5 + 1 - e0;
      in_b = 2'b11;
      for (int k = 0; k <= 27; k++) begin
        @(negedge clk);
        n_total++;
        if (prs_b !== ((k == lat) ? 2'b11 : 2'b00))
          $display("FAIL tick_div phase %0d edge %0d: got press %b required %b", r, k, prs_b,
                   (k == lat) ? 2'b11 : 2'b00);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int hold_a [2];
    int hold_b [2];
    do_reset();
    for (int c = 0; c < 2; c++) begin
      hold_a[c] = 0;
      hold_b[c] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_total++;
      if ({lvl_a, prs_a, rel_a} !== {exp_level[0], exp_press[0], exp_rel[0]})
        $display("FAIL random_a cyc %0d: got lvl/prs/rel %b required %b", cyc,
                 {lvl_a, prs_a, rel_a}, {exp_level[0], exp_press[0], exp_rel[0]});
      else n_pass++;
      n_total++;
      if ({lvl_b, prs_b, rel_b} !== {exp_level[1], exp_press[1], exp_rel[1]})
        $display("FAIL random_b cyc %0d: got lvl/prs/rel %b required %b", cyc,
                 {lvl_b, prs_b, rel_b}, {exp_level[1], exp_press[1], exp_rel[1]});
      else n_pass++;
      for (int c = 0; c < 2; c++) begin
        if (hold_a[c] == 0) begin
          in_a[c]   = 1'($urandom_range(0, 1));
          hold_a[c] = $urandom_range(1, 12);
        end else hold_a[c]--;
        if (hold_b[c] == 0) begin
          in_b[c]   = 1'($urandom_range(0, 1));
          hold_b[c] = $urandom_range(1, 45);
        end else hold_b[c]--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_release();
    test_autorepeat();
    test_reset_mid();
    test_tick_div();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
